// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for a three-stage-register pipeline.
// Drives per-register enable/flush controls for PC, IF/ID, ID/EX and EX/WB.
// Handles taken branches, load-use hazards, multi-cycle multiplies and external
// halt requests. Also keeps a saturating stall-cycle counter for debug.
module pipe_ctrl #(
  parameter int unsigned MUL_CYCLES = 4,  // total EX residency of a multiply, 2..15
  parameter int unsigned RA_W       = 3   // register-address width
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] id_rs1_i,
  input  logic [RA_W-1:0] id_rs2_i,
  input  logic            id_uses_rs1_i,
  input  logic            id_uses_rs2_i,
  input  logic [RA_W-1:0] ex_rd_i,
  input  logic            ex_is_load_i,
  input  logic            ex_is_mul_i,
  input  logic            ex_taken_i,
  input  logic            halt_req_i,
  output logic            pc_en_o,
  output logic            ifid_en_o,
  output logic            idex_en_o,
  output logic            exwb_en_o,
  output logic            ifid_flush_o,
  output logic            idex_flush_o,
  output logic            exwb_flush_o,
  output logic            mul_busy_o,
  output logic            halted_o,
  output logic [7:0]      stall_cnt_o
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_MULWAIT = 2'd1,
    S_HALT    = 2'd2
  } state_e;

  // Bundle of all per-cycle pipeline controls, so each situation is one constant.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exwb_flush;
    logic mul_busy;
    logic halted;
  } ctrl_t;

  // Every register loads, no bubbles.
  localparam ctrl_t CTRL_ADVANCE = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exwb_en: 1'b1,
                                     ifid_flush: 1'b0, idex_flush: 1'b0, exwb_flush: 1'b0,
                                     mul_busy: 1'b0, halted: 1'b0};
  // Taken branch: advance, and squash the two wrong-path instructions behind it.
  localparam ctrl_t CTRL_BRANCH  = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exwb_en: 1'b1,
                                     ifid_flush: 1'b1, idex_flush: 1'b1, exwb_flush: 1'b0,
                                     mul_busy: 1'b0, halted: 1'b0};
  // Multiply holding EX: front end frozen, WB receives a bubble each cycle.
  localparam ctrl_t CTRL_MUL     = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exwb_en: 1'b1,
                                     ifid_flush: 1'b0, idex_flush: 1'b0, exwb_flush: 1'b1,
                                     mul_busy: 1'b1, halted: 1'b0};
  // Load-use: hold PC and IF/ID, bubble into ID/EX, let the load move on to WB.
  localparam ctrl_t CTRL_LDUSE   = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b1, exwb_en: 1'b1,
                                     ifid_flush: 1'b0, idex_flush: 1'b1, exwb_flush: 1'b0,
                                     mul_busy: 1'b0, halted: 1'b0};
  // Halted: everything frozen in place.
  localparam ctrl_t CTRL_HALT    = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exwb_en: 1'b0,
                                     ifid_flush: 1'b0, idex_flush: 1'b0, exwb_flush: 1'b0,
                                     mul_busy: 1'b0, halted: 1'b1};
  // In reset: nothing loads, every register is forced to a bubble.
  localparam ctrl_t CTRL_RESET   = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exwb_en: 1'b0,
                                     ifid_flush: 1'b1, idex_flush: 1'b1, exwb_flush: 1'b1,
                                     mul_busy: 1'b0, halted: 1'b0};

  // Remaining-cycle count loaded when a multiply is first seen in RUN.
  localparam logic [3:0] MCNT_INIT = 4'(MUL_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] mcnt_q, mcnt_d;
  logic [7:0] stall_cnt_q, stall_cnt_d;
  ctrl_t      ctrl;
  logic       load_use;

  // Load-use hazard: the load in EX writes a register that ID is about to read.
  // x0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use = ex_is_load_i && (ex_rd_i != '0) &&
                    ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                     (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));

  // Next-state and control outputs, decoded from state, mcnt and hazard inputs.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves a
    // value unassigned and no latch is inferred.
    state_d = state_q;
    mcnt_d  = mcnt_q;
    ctrl    = CTRL_ADVANCE;
    if (rst) begin
      ctrl = CTRL_RESET;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (ex_taken_i) begin
            ctrl = CTRL_BRANCH;
          end else if (ex_is_mul_i) begin
            ctrl    = CTRL_MUL;
            state_d = S_MULWAIT;
            mcnt_d  = MCNT_INIT;
          end else if (load_use) begin
            ctrl = CTRL_LDUSE;
          end else if (halt_req_i) begin
            ctrl    = CTRL_ADVANCE;
            state_d = S_HALT;
          end else begin
            ctrl = CTRL_ADVANCE;
          end
        end
        S_MULWAIT: begin
          // Branch, load-use and halt cannot apply while the multiply owns EX.
          if (mcnt_q > 4'd1) begin
            ctrl   = CTRL_MUL;
            mcnt_d = mcnt_q - 4'd1;
          end else begin
            ctrl    = CTRL_ADVANCE;
            state_d = S_RUN;
            mcnt_d  = 4'd0;
          end
        end
        S_HALT: begin
          // The release cycle is still frozen; advance resumes the cycle after.
          ctrl = CTRL_HALT;
          if (!halt_req_i) state_d = S_RUN;
        end
        default: begin
          ctrl    = CTRL_RESET;
          state_d = S_RUN;
          mcnt_d  = 4'd0;
        end
      endcase
    end
  end

  // Stall counter advances on frozen-PC cycles outside HALT and saturates at 255.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!rst && !ctrl.pc_en && (state_q != S_HALT) && (stall_cnt_q != 8'hFF)) begin
      stall_cnt_d = stall_cnt_q + 8'd1;
    end
  end

  // State, multiply countdown and stall counter registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= S_RUN;
      mcnt_q      <= 4'd0;
      stall_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      mcnt_q      <= mcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pc_en_o      = ctrl.pc_en;
  assign ifid_en_o    = ctrl.ifid_en;
  assign idex_en_o    = ctrl.idex_en;
  assign exwb_en_o    = ctrl.exwb_en;
  assign ifid_flush_o = ctrl.ifid_flush;
  assign idex_flush_o = ctrl.idex_flush;
  assign exwb_flush_o = ctrl.exwb_flush;
  assign mul_busy_o   = ctrl.mul_busy;
  assign halted_o     = ctrl.halted;
  assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a driver issues one stimulus per cycle and
// pushes the reference model's expected controls; a monitor pops and compares.
module tb_pipe_ctrl;

  localparam int MUL_CYCLES = 4;
  localparam int RA_W       = 3;

  // Expected control vectors, bit order:
  // {pc_en, ifid_en, idex_en, exwb_en, ifid_flush, idex_flush, exwb_flush, mul_busy, halted}
  localparam logic [8:0] C_ADV    = 9'b1111_000_00;
  localparam logic [8:0] C_BRANCH = 9'b1111_110_00;
  localparam logic [8:0] C_MUL    = 9'b0000_001_10;
  localparam logic [8:0] C_LDUSE  = 9'b0001_010_00;
  localparam logic [8:0] C_HALT   = 9'b0000_000_01;
  localparam logic [8:0] C_RESET  = 9'b0000_111_00;
  // Enables that are don't-care because the matching flush overrides them.
  localparam logic [8:0] M_NONE    = 9'b0;
  localparam logic [8:0] M_IDEX_EN = 9'b0010_000_00;
  localparam logic [8:0] M_EXWB_EN = 9'b0001_000_00;

  typedef struct packed {
    logic            rst;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic            u1;
    logic            u2;
    logic            load;
    logic            mul;
    logic            taken;
    logic            halt;
  } stim_t;

  typedef struct packed {
    logic [8:0] ctrl;
    logic [8:0] mask;
    logic [7:0] stall_cnt;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [RA_W-1:0] id_rs1_i = '0, id_rs2_i = '0, ex_rd_i = '0;
  logic            id_uses_rs1_i = 1'b0, id_uses_rs2_i = 1'b0;
  logic            ex_is_load_i = 1'b0, ex_is_mul_i = 1'b0, ex_taken_i = 1'b0, halt_req_i = 1'b0;
  logic            pc_en_o, ifid_en_o, idex_en_o, exwb_en_o;
  logic            ifid_flush_o, idex_flush_o, exwb_flush_o, mul_busy_o, halted_o;
  logic [7:0]      stall_cnt_o;

  always #5 clk = ~clk;

  pipe_ctrl #(.MUL_CYCLES(MUL_CYCLES), .RA_W(RA_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
    .ex_rd_i(ex_rd_i), .ex_is_load_i(ex_is_load_i), .ex_is_mul_i(ex_is_mul_i),
    .ex_taken_i(ex_taken_i), .halt_req_i(halt_req_i),
    .pc_en_o(pc_en_o), .ifid_en_o(ifid_en_o), .idex_en_o(idex_en_o), .exwb_en_o(exwb_en_o),
    .ifid_flush_o(ifid_flush_o), .idex_flush_o(idex_flush_o), .exwb_flush_o(exwb_flush_o),
    .mul_busy_o(mul_busy_o), .halted_o(halted_o), .stall_cnt_o(stall_cnt_o)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, want);
    end
  endtask

  // Reference model: a multiply owes a number of further stall cycles, a halt
  // is a flag, and the stall total is a plain integer clipped at 255.
  int m_mul_owed = -1;  // -1: no multiply in EX; 0: multiply leaves this cycle
  bit m_halted   = 1'b0;
  int m_stalls   = 0;

  task automatic model_step(input stim_t s, output exp_t e);
    bit lu;
    bit counts;
    e      = '0;
    counts = 1'b0;
    lu = s.load && (s.rd != 0) &&
         ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    if (s.rst) begin
      m_mul_owed = -1;
      m_halted   = 1'b0;
      m_stalls   = 0;
      e.ctrl     = C_RESET;
    end else begin
      e.stall_cnt = 8'(m_stalls);
      if (m_halted) begin
        e.ctrl = C_HALT;
        if (!s.halt) m_halted = 1'b0;
      end else begin
        counts = 1'b1;
        if (m_mul_owed > 0) begin
          e.ctrl = C_MUL; e.mask = M_EXWB_EN;
          m_mul_owed--;
        end else if (m_mul_owed == 0) begin
          e.ctrl = C_ADV;
          m_mul_owed = -1;
        end else if (s.taken) begin
          e.ctrl = C_BRANCH;
        end else if (s.mul) begin
          e.ctrl = C_MUL; e.mask = M_EXWB_EN;
          m_mul_owed = MUL_CYCLES - 2;
        end else if (lu) begin
          e.ctrl = C_LDUSE; e.mask = M_IDEX_EN;
        end else if (s.halt) begin
          e.ctrl = C_ADV;
          m_halted = 1'b1;
        end else begin
          e.ctrl = C_ADV;
        end
      end
      if (counts && !e.ctrl[8] && m_stalls < 255) m_stalls++;
    end
  endtask

  // One cycle of stimulus: apply just after the rising edge, queue the expectation.
  task automatic drive(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    rst           = s.rst;
    id_rs1_i      = s.rs1;
    id_rs2_i      = s.rs2;
    ex_rd_i       = s.rd;
    id_uses_rs1_i = s.u1;
    id_uses_rs2_i = s.u2;
    ex_is_load_i  = s.load;
    ex_is_mul_i   = s.mul;
    ex_taken_i    = s.taken;
    halt_req_i    = s.halt;
    model_step(s, e);
    exp_q.push_back(e);
  endtask

  function automatic stim_t idle();
    return '0;
  endfunction

  function automatic stim_t ld_use(input logic [RA_W-1:0] rd);
    stim_t s = '0;
    s.load = 1'b1; s.rd = rd; s.rs2 = 3'd3; s.u2 = 1'b1; s.rs1 = 3'd5; s.u1 = 1'b1;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s = '0;
    s.rst   = ($urandom_range(0, 149) == 0);
    s.rd    = 3'($urandom_range(0, 7));
    s.rs1   = ($urandom_range(0, 1) == 0) ? s.rd : 3'($urandom_range(0, 7));
    s.rs2   = ($urandom_range(0, 1) == 0) ? s.rd : 3'($urandom_range(0, 7));
    s.u1    = 1'($urandom_range(0, 1));
    s.u2    = 1'($urandom_range(0, 1));
    s.load  = ($urandom_range(0, 2) == 0);
    s.mul   = ($urandom_range(0, 7) == 0);
    s.taken = ($urandom_range(0, 7) == 0);
    s.halt  = ($urandom_range(0, 5) == 0);
    return s;
  endfunction

  // Monitor: the DUT presents a full control word every cycle; compare mid-cycle.
  int         mon_cyc = 0;
  exp_t       mon_e;
  logic [8:0] mon_act;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_act = {pc_en_o, ifid_en_o, idex_en_o, exwb_en_o,
                 ifid_flush_o, idex_flush_o, exwb_flush_o, mul_busy_o, halted_o};
      check($sformatf("cyc%0d ctrl", mon_cyc), 32'(mon_act & ~mon_e.mask),
            32'(mon_e.ctrl & ~mon_e.mask));
      check($sformatf("cyc%0d stall_cnt", mon_cyc), 32'(stall_cnt_o), 32'(mon_e.stall_cnt));
      mon_cyc++;
    end
  end

  // Direct spot checks of the headline numbers, independent of the model.
  task automatic spot(input string name, input logic [31:0] act_sel, input logic [31:0] want);
    check(name, act_sel, want);
  endtask

  initial begin
    stim_t s;

    // Reset, then five hazard-free cycles.
    s = idle(); s.rst = 1'b1;
    drive(s); drive(s);
    repeat (5) drive(idle());
    @(negedge clk); #1;
    spot("run pc_en", 32'(pc_en_o), 32'd1);
    spot("run stall_cnt", 32'(stall_cnt_o), 32'd0);

    // Load-use on rs2 = x3: one bubble.
    drive(ld_use(3'd3));
    @(negedge clk); #1;
    spot("lu pc_en", 32'(pc_en_o), 32'd0);
    spot("lu exwb_en", 32'(exwb_en_o), 32'd1);
    spot("lu idex_flush", 32'(idex_flush_o), 32'd1);
    drive(idle());
    @(negedge clk); #1;
    spot("lu stall_cnt", 32'(stall_cnt_o), 32'd1);

    // Same pattern targeting x0: no stall.
    drive(ld_use(3'd0));
    @(negedge clk); #1;
    spot("lu x0 pc_en", 32'(pc_en_o), 32'd1);

    // Multiply held for MUL_CYCLES cycles: 3 stalls then advance.
    s = idle(); s.mul = 1'b1;
    repeat (3) drive(s);
    @(negedge clk); #1;
    spot("mul busy", 32'(mul_busy_o), 32'd1);
    drive(s);
    @(negedge clk); #1;
    spot("mul done pc_en", 32'(pc_en_o), 32'd1);
    spot("mul done busy", 32'(mul_busy_o), 32'd0);
    drive(idle());
    @(negedge clk); #1;
    spot("mul stall_cnt", 32'(stall_cnt_o), 32'd4);

    // Branch and multiply together: branch wins, multiply never entered.
    s = idle(); s.mul = 1'b1; s.taken = 1'b1;
    drive(s);
    @(negedge clk); #1;
    spot("br+mul busy", 32'(mul_busy_o), 32'd0);
    spot("br+mul flush", 32'({ifid_flush_o, idex_flush_o}), 32'd3);
    drive(idle());
    @(negedge clk); #1;
    spot("br+mul next pc_en", 32'(pc_en_o), 32'd1);

    // Halt requested for 3 cycles, then released.
    s = idle(); s.halt = 1'b1;
    repeat (3) drive(s);
    drive(idle());
    @(negedge clk); #1;
    spot("halt release frozen", 32'(halted_o), 32'd1);
    drive(idle());
    @(negedge clk); #1;
    spot("halt resume pc_en", 32'(pc_en_o), 32'd1);
    spot("halt stall_cnt", 32'(stall_cnt_o), 32'd4);

    // 300 consecutive load-use cycles: counter saturates.
    repeat (300) drive(ld_use(3'd3));
    drive(idle());
    @(negedge clk); #1;
    spot("sat stall_cnt", 32'(stall_cnt_o), 32'd255);

    // Asynchronous reset in the middle of a multiply wait.
    s = idle(); s.mul = 1'b1;
    drive(s); drive(s);
    s = idle(); s.rst = 1'b1;
    drive(s);
    @(negedge clk); #1;
    spot("rst mulwait busy", 32'(mul_busy_o), 32'd0);
    spot("rst mulwait flush", 32'({ifid_flush_o, idex_flush_o, exwb_flush_o}), 32'd7);
    drive(idle());
    @(negedge clk); #1;
    spot("post rst pc_en", 32'(pc_en_o), 32'd1);
    spot("post rst stall_cnt", 32'(stall_cnt_o), 32'd0);

    // Randomised traffic against the reference model.
    repeat (1500) drive(rand_stim());
    drive(idle());

    @(negedge clk); #1;
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
